// File: rtl/sale_terminal_pkg.sv
// Shared sale-terminal types: direction codes and keypad FSM states.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package sale_terminal_pkg;

  // Direction codes shared with the product-cursor stage.
  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_UP    = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
    REPEAT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } keypad_state_e;

  // A valid press is exactly one key down.
  function automatic logic is_onehot4(input logic [3:0] p);
    return (p != 4'b0000) && ((p & (p - 4'd1)) == 4'b0000);
  endfunction

  // Key pattern bit order is [3] left, [2] up, [1] down, [0] right.
  function automatic logic [1:0] dir_encode(input logic [3:0] p);
    logic [1:0] d;
    case (p)
      4'b1000: d = DIR_LEFT;
      4'b0100: d = DIR_UP;
      4'b0010: d = DIR_DOWN;
      default: d = DIR_RIGHT;
    endcase
    return d;
  endfunction

  // Inverse of dir_encode: the one-hot pattern a direction code came from.
  function automatic logic [3:0] dir_decode(input logic [1:0] d);
    return 4'b1000 >> d;
  endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// Two-flop synchroniser plus debouncer for active-low keys; output is active-high.
// Latency: DEBOUNCE_CYCLES+2 clocks from first sampling edge to stable_o update.
// Backpressure: none; free-running, stable_o is a level.
module key_sync_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] key_n_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Synchroniser flops hold raw active-low levels, so "released" is all ones.
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] synced;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign synced   = ~sync2_q;
  assign stable_o = stable_q;

  // Debounce next state: restart on any change, accept after the full quiet window,
  // then hold the counter at its last value so it never wraps.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (synced != cand_q) begin
      cand_d = synced;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/direction_keypad.sv
// Direction keypad: debounced one-hot key -> registered direction strobe with auto-repeat.
// Latency: DEBOUNCE_CYCLES+3 clocks from first sampling edge to Enable.
// Backpressure: none; Enable is a one-clock strobe, Active=0 parks the FSM until release.
module direction_keypad
  import sale_terminal_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] KEY_N,
  input  logic       Active,
  output logic [1:0] Dir_out,
  output logic       Enable
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  // Counter is loaded with N-1 and expires at zero, so pulses land N clocks apart.
  localparam logic [RW-1:0] DELAY_LOAD = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LOAD  = RW'(REPEAT_RATE - 1);

  logic [3:0]    stable;
  logic          same_key;
  keypad_state_e state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          enable_q, enable_d;
  logic [1:0]    dir_q, dir_d;

  key_sync_debounce #(
    .WIDTH          (4),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i   (CLOCK),
    .rst_i   (RESET),
    .key_n_i (KEY_N),
    .stable_o(stable)
  );

  // dir_q always holds the key being repeated, so it doubles as the held-key record.
  assign same_key = (stable == dir_decode(dir_q));
  assign Dir_out  = dir_q;
  assign Enable   = enable_q;

  // Next-state and strobe decode; a stable-pattern change wins over counter expiry.
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    enable_d = 1'b0;
    dir_d    = dir_q;
    if (!Active) begin
      state_d = WAIT_RELEASE;
    end else begin
      case (state_q)
        IDLE: begin
          if (is_onehot4(stable)) begin
            enable_d = 1'b1;
            dir_d    = dir_encode(stable);
            rcnt_d   = DELAY_LOAD;
            state_d  = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!same_key) begin
            state_d = IDLE;
          end else if (rcnt_q == '0) begin
            enable_d = 1'b1;
            rcnt_d   = RATE_LOAD;
            state_d  = REPEAT;
          end else begin
            rcnt_d = rcnt_q - 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (stable == 4'b0000) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM, repeat counter and registered outputs.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= IDLE;
      rcnt_q   <= '0;
      enable_q <= 1'b0;
      dir_q    <= DIR_LEFT;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      enable_q <= enable_d;
      dir_q    <= dir_d;
    end
  end

endmodule

// File: tb/tb_direction_keypad.sv
// Directed table-driven bench for direction_keypad with short debounce/repeat timing.
// Latency: expects first strobe 7 clocks after the first sampling edge.
// Backpressure: n/a.
module tb_direction_keypad;
  import sale_terminal_pkg::*;

  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [3:0] KEY_N;
  logic       Active;
  logic [1:0] Dir_out;
  logic       Enable;

  int tests = 0;
  int fails = 0;
  logic [1:0] last_dir;

  direction_keypad #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3)
  ) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .KEY_N  (KEY_N),
    .Active (Active),
    .Dir_out(Dir_out),
    .Enable (Enable)
  );

  always #5 CLOCK = ~CLOCK;

  // One step: drive key/active, run cyc clocks, expect strobes exactly at cycles p0..p3
  // (cycle 1 is the first edge sampling the new inputs; 0 means unused).
  typedef struct {
    logic [3:0] key_n;
    logic [3:0] tog;
    logic       act;
    int         cyc;
    int         p0, p1, p2, p3;
    logic [1:0] dir;
  } step_t;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic run_step(input int id, input step_t s);
    int en_bad = 0;
    int dir_bad = 0;
    int first_bad = 0;
    logic exp_en;
    KEY_N  = s.key_n;
    Active = s.act;
    for (int k = 1; k <= s.cyc; k++) begin
      @(posedge CLOCK);
      #1;
      exp_en = (k == s.p0) || (k == s.p1) || (k == s.p2) || (k == s.p3);
      if (exp_en) last_dir = s.dir;
      if (Enable !== exp_en) begin
        if (en_bad == 0) first_bad = k;
        en_bad++;
      end
      if (Dir_out !== last_dir) dir_bad++;
      KEY_N = KEY_N ^ s.tog;
    end
    check($sformatf("step%0d enable mismatch cycles (first at cycle %0d)", id, first_bad), en_bad, 0);
    check($sformatf("step%0d dir_out mismatch cycles", id), dir_bad, 0);
  endtask

  step_t steps[12];

  initial begin
    // Steady left press with auto-repeat, then release (two repeats land before release settles).
    steps[0]  = '{4'b0111, 4'b0000, 1'b1, 24,  8, 18, 21, 24, DIR_LEFT};
    steps[1]  = '{4'b1111, 4'b0000, 1'b1, 12,  3,  6,  0,  0, DIR_LEFT};
    // Bouncing down key never settles, then released.
    steps[2]  = '{4'b1101, 4'b0010, 1'b1, 20,  0,  0,  0,  0, DIR_LEFT};
    steps[3]  = '{4'b1111, 4'b0000, 1'b1, 12,  0,  0,  0,  0, DIR_LEFT};
    // Left+up together is invalid; dropping up leaves a valid left.
    steps[4]  = '{4'b0011, 4'b0000, 1'b1, 15,  0,  0,  0,  0, DIR_LEFT};
    steps[5]  = '{4'b0111, 4'b0000, 1'b1, 10,  8,  0,  0,  0, DIR_LEFT};
    // Release lands on the same clock the first repeat would have fired: no pulse.
    steps[6]  = '{4'b1111, 4'b0000, 1'b1, 12,  0,  0,  0,  0, DIR_LEFT};
    // Right held across a mode change is never emitted; a fresh press is.
    steps[7]  = '{4'b1110, 4'b0000, 1'b0, 12,  0,  0,  0,  0, DIR_RIGHT};
    steps[8]  = '{4'b1110, 4'b0000, 1'b1, 12,  0,  0,  0,  0, DIR_RIGHT};
    steps[9]  = '{4'b1111, 4'b0000, 1'b1, 12,  0,  0,  0,  0, DIR_RIGHT};
    steps[10] = '{4'b1110, 4'b0000, 1'b1, 10,  8,  0,  0,  0, DIR_RIGHT};
    steps[11] = '{4'b1111, 4'b0000, 1'b1, 12,  0,  0,  0,  0, DIR_RIGHT};

    RESET    = 1'b1;
    KEY_N    = 4'b1111;
    Active   = 1'b1;
    last_dir = DIR_LEFT;
    repeat (3) @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    check("reset enable", int'(Enable), 0);
    check("reset dir_out", int'(Dir_out), int'(DIR_LEFT));
    check("reset state", int'(dut.state_q), int'(IDLE));

    for (int i = 0; i < 12; i++) run_step(i, steps[i]);

    // Down held into REPEAT; reset lands on the clock after the second strobe.
    run_step(12, '{4'b1101, 4'b0000, 1'b1, 18, 8, 18, 0, 0, DIR_DOWN});
    RESET = 1'b1;
    @(posedge CLOCK);
    #1;
    RESET = 1'b0;
    last_dir = DIR_LEFT;
    check("post-reset enable", int'(Enable), 0);
    check("post-reset dir_out", int'(Dir_out), int'(DIR_LEFT));
    check("post-reset state", int'(dut.state_q), int'(IDLE));
    // Key still held: full debounce latency again, no surviving repeat.
    run_step(13, '{4'b1101, 4'b0000, 1'b1, 12, 8, 0, 0, 0, DIR_DOWN});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
